byte_to_word_rx: RTL and testbench
==================================

BYTE_TO_WORD_RX -- requirements
Module: byte_to_word_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have port `clock` (input, 1): the only clock; all logic on the rising edge.
REQ-003 SHALL have port `reset_n` (input, 1): asynchronous, active-low reset.
REQ-004 SHALL have port `enable` (input, 1): receiver active when high.
REQ-005 SHALL have port `i_mode_select` (input, 1): 0 = byte mode, 1 = word mode.
REQ-006 SHALL have port `i_serial` (input, 1): UART line, idle high.
REQ-007 SHALL have port `o_byte` (output, 8): last received byte.
REQ-008 SHALL have port `o_byte_valid` (output, 1): one-cycle pulse per good byte.
REQ-009 SHALL have port `o_word` (output, 32): last assembled word.
REQ-010 SHALL have port `o_word_valid` (output, 1): one-cycle pulse per completed word.
REQ-011 SHALL have port `o_frame_error` (output, 1): one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port `o_parity_error` (output, 1): one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-013 SHALL pass i_serial through a 2-flop synchronizer; the FSM uses only the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a synchronized low while enable=1.
REQ-015 SHALL re-sample the line in START after CLKS_PER_BIT/2 cycles.
- Low: go to DATA and reset the bit counter.
- High (glitch): return to IDLE with no output.
REQ-016 SHALL sample 8 data bits in DATA, LSB first, each CLKS_PER_BIT cycles after the previous sample (mid-bit).
REQ-017 SHALL sample the stop bit in STOP and act on it the cycle after that sample:
- Stop bit high: pulse o_byte_valid and update o_byte in the same cycle.
- Stop bit low: pulse o_frame_error; o_byte is unchanged; the byte is discarded.
REQ-018 SHALL return from STOP to IDLE immediately, so back-to-back frames with a single stop bit are received without loss.
REQ-019 SHALL, in word mode, shift each good byte into o_word's staging register little-endian: first byte to [7:0], fourth byte to [31:24].
REQ-020 SHALL keep a 2-bit byte index; after the 4th good byte, pulse o_word_valid coincident with that byte's o_byte_valid, update o_word, and wrap the index to 0.
REQ-021 SHALL clear the byte index and staging register on: a frame error, a parity error, any i_mode_select change, or enable low.
REQ-022 SHALL, in byte mode, not assert o_word_valid and hold o_word unchanged.
REQ-023 SHALL, when enable goes low mid-frame, abort to IDLE on the next clock with no valid or error pulse.
REQ-024 SHALL, while enable is low, keep the FSM in IDLE and ignore i_serial.

Reset
REQ-025 SHALL, while reset_n=0, immediately (asynchronously) force:
- FSM to IDLE;
- all counters, the index and the staging register to 0;
- o_byte=0x00, o_word=0x00000000;
- all pulse outputs to 0;
- synchronizer flops to 1.
REQ-026 SHALL, when reset is asserted mid-frame, drop the partial frame and partial word with no pulse after release.

Configuration
REQ-027 SHALL, with macro UART_RX_PARITY_EN defined, expect an even-parity bit between bit 7 and the stop bit.
- The PARITY state samples it.
- On mismatch, pulse o_parity_error at the stop-bit decision cycle and discard the byte.
- A frame error takes precedence; only o_frame_error pulses.
REQ-028 SHALL, without UART_RX_PARITY_EN, never enter the PARITY state (8N1 framing) and tie o_parity_error to 0.

Structure
REQ-029 SHALL place in shared package `uart_pkg`:
- the FSM state encoding;
- the CLKS_PER_BIT default constant;
- the byte-index width.
REQ-030 SHALL split bit-level reception into sub-module `uart_rx_byte` (synchronizer, FSM, bit counter, parity check); byte_to_word_rx instantiates it and holds the word assembler.

Verification (bench CLKS_PER_BIT=16, driven by word_to_byte_tx)
REQ-031 SHALL cover byte mode: send 0xAB, then 0x10 -> o_byte_valid pulses twice with o_byte 0xAB then 0x10; o_word_valid never asserts.
REQ-032 SHALL cover word mode: send bytes CD,12,FF,00 -> one o_word_valid with o_word=0x00FF12CD, coincident with the 4th o_byte_valid.
REQ-033 SHALL cover error recovery: force the stop bit low on the 2nd byte of a word -> o_frame_error pulses once; the next 4 good bytes 01,02,03,04 give o_word=0x04030201.
REQ-034 SHALL cover a start glitch: 4-cycle low pulse on idle i_serial -> no pulse output; the following 0x55 is received correctly.
REQ-035 SHALL cover reset mid-frame: assert reset_n=0 during bit 3 -> o_byte=0x00 and no pulses; the next 0x3C is received correctly.
REQ-036 SHALL cover parity, with UART_RX_PARITY_EN defined: send 0x01 with parity bit 0 -> o_parity_error pulses and o_byte_valid does not.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM encoding, default bit timing, word byte-index width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // 100 MHz clock at 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    localparam int unsigned BYTE_IDX_W = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level UART receiver: synchronizer, framing FSM, bit timing and optional even-parity check.
// Parity bit is expected only when UART_RX_PARITY_EN is defined (otherwise 8N1).
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       i_serial,
    output logic [7:0] rx_data,
    output logic       byte_ok,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state, state_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             half_tick, bit_tick, stop_tick;

    assign half_tick = (clk_cnt == HALF_LAST);
    assign bit_tick  = (clk_cnt == FULL_LAST);
    assign rx_data   = shreg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:   if (!rx_sync) state_next = START;
                START:  if (half_tick) state_next = rx_sync ? IDLE : DATA;
                DATA: begin
                    if (bit_tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
                PARITY: if (bit_tick) state_next = STOP;
                STOP:   if (bit_tick) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Counter restarts on every state change so START measures half a bit and later states full bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || state_next != state || bit_tick) clk_cnt <= '0;
            else                                                   clk_cnt <= clk_cnt + 1'b1;
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_tick) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= {rx_sync, shreg[7:1]};
            end
        end
    end

    assign stop_tick = enable && (state == STOP) && bit_tick;
    assign frame_err = stop_tick && !rx_sync;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          par_bit <= 1'b0;
        else if (state == PARITY && bit_tick) par_bit <= rx_sync;
    end

    assign parity_err = stop_tick && rx_sync && (^{shreg, par_bit});
`else
    assign parity_err = 1'b0;
`endif

    assign byte_ok = stop_tick && rx_sync && !parity_err;

endmodule

// File: rtl/byte_to_word_rx.sv
// UART receiver delivering single bytes, or in word mode 32-bit little-endian words of four bytes.
// Define UART_RX_PARITY_EN for even-parity framing (8E1); default is 8N1.
module byte_to_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        i_mode_select,
    input  logic        i_serial,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_frame_error,
    output logic        o_parity_error
);

    logic [7:0]            rx_data;
    logic                  byte_ok, frame_err, parity_err;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [31:0]           staging;
    logic                  mode_q;
    logic                  word_clear;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .i_serial   (i_serial),
        .rx_data    (rx_data),
        .byte_ok    (byte_ok),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    assign word_clear = !enable || frame_err || parity_err || (i_mode_select != mode_q);

    // Decision strobes are registered here so the 4th byte and its word pulse together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q        <= 1'b0;
            o_byte        <= '0;
            o_byte_valid  <= 1'b0;
            o_word        <= '0;
            o_word_valid  <= 1'b0;
            o_frame_error <= 1'b0;
            byte_idx      <= '0;
            staging       <= '0;
        end else begin
            mode_q        <= i_mode_select;
            o_byte_valid  <= byte_ok;
            o_frame_error <= frame_err;
            o_word_valid  <= 1'b0;
            if (byte_ok) o_byte <= rx_data;
            if (word_clear) begin
                byte_idx <= '0;
                staging  <= '0;
            end else if (byte_ok && i_mode_select) begin
                if (byte_idx == '1) begin
                    o_word       <= {rx_data, staging[23:0]};
                    o_word_valid <= 1'b1;
                    byte_idx     <= '0;
                    staging      <= '0;
                end else begin
                    staging[{byte_idx, 3'b000} +: 8] <= rx_data;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) o_parity_error <= 1'b0;
        else          o_parity_error <= parity_err;
    end
`else
    assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_byte_to_word_rx.sv
// Directed bench for byte_to_word_rx: serial frames driven by tasks, byte/word scoreboard queues.
module tb_byte_to_word_rx;

    localparam int unsigned CPB = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        i_mode_select = 1'b0;
    logic        i_serial = 1'b1;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        o_frame_error;
    logic        o_parity_error;

    int vectors = 0;
    int miscompares = 0;
    int byte_cnt = 0;
    int word_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];

    always #5 clock = ~clock;

    byte_to_word_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .i_mode_select  (i_mode_select),
        .i_serial       (i_serial),
        .o_byte         (o_byte),
        .o_byte_valid   (o_byte_valid),
        .o_word         (o_word),
        .o_word_valid   (o_word_valid),
        .o_frame_error  (o_frame_error),
        .o_parity_error (o_parity_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        i_serial = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_bit);
        i_serial = 1'b1;
    endtask

    // Scoreboard side: pops on each output pulse, sampled on the falling edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (o_byte_valid) begin
                byte_cnt++;
                check("byte_expected", 32'(o_byte_valid), 32'(exp_bytes.size() != 0));
                if (exp_bytes.size() != 0) check("byte_value", 32'(o_byte), 32'(exp_bytes.pop_front()));
            end
            if (o_word_valid) begin
                word_cnt++;
                check("word_with_byte", 32'(o_byte_valid), 32'd1);
                check("word_expected", 32'(o_word_valid), 32'(exp_words.size() != 0));
                if (exp_words.size() != 0) check("word_value", o_word, exp_words.pop_front());
            end
            if (o_frame_error) ferr_cnt++;
            if (o_parity_error) perr_cnt++;
        end
    end

    initial begin
        @(negedge clock);
        check("rst_byte", 32'(o_byte), 32'h0);
        check("rst_word", o_word, 32'h0);
        check("rst_pulses", 32'({o_byte_valid, o_word_valid, o_frame_error, o_parity_error}), 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Byte mode
        exp_bytes.push_back(8'hAB);
        exp_bytes.push_back(8'h10);
        send_byte(8'hAB, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (20) @(negedge clock);
        check("bytemode_count", 32'(byte_cnt), 32'd2);
        check("bytemode_no_word", 32'(word_cnt), 32'd0);
        check("bytemode_last", 32'(o_byte), 32'h10);
        check("bytemode_word_held", o_word, 32'h0);

        // Word mode
        i_mode_select = 1'b1;
        repeat (4) @(negedge clock);
        foreach (exp_bytes[i]) check("queue_drained", 32'(i), 32'hFFFF_FFFF);
        exp_bytes.push_back(8'hCD);
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'h00);
        exp_words.push_back(32'h00FF12CD);
        send_byte(8'hCD, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clock);
        check("word_count", 32'(word_cnt), 32'd1);
        check("word_out", o_word, 32'h00FF12CD);

        // Frame error on 2nd byte of a word clears the partial word
        exp_bytes.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b0);
        repeat (2 * CPB) @(negedge clock);
        check("ferr_count", 32'(ferr_cnt), 32'd1);
        check("ferr_byte_held", 32'(o_byte), 32'h77);
        for (int b = 1; b <= 4; b++) exp_bytes.push_back(8'(b));
        exp_words.push_back(32'h04030201);
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
        repeat (20) @(negedge clock);
        check("recover_word_count", 32'(word_cnt), 32'd2);
        check("recover_word", o_word, 32'h04030201);
        check("recover_byte_count", 32'(byte_cnt), 32'd11);

        // Start glitch
        i_mode_select = 1'b0;
        repeat (4) @(negedge clock);
        i_serial = 1'b0;
        repeat (4) @(negedge clock);
        i_serial = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("glitch_no_byte", 32'(byte_cnt), 32'd11);
        check("glitch_no_ferr", 32'(ferr_cnt), 32'd1);
        exp_bytes.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clock);
        check("glitch_next_byte", 32'(o_byte), 32'h55);
        check("bytemode_word_hold2", o_word, 32'h04030201);

        // Reset during data bit 3 of a partial frame
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        i_serial = 1'b1;
        repeat (CPB / 2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_byte", 32'(o_byte), 32'h0);
        check("midrst_word", o_word, 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (12 * CPB) @(negedge clock);
        check("midrst_no_pulse", 32'(byte_cnt + ferr_cnt + perr_cnt), 32'd13);
        check("midrst_byte_after", 32'(o_byte), 32'h0);
        exp_bytes.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clock);
        check("midrst_next_byte", 32'(o_byte), 32'h3C);
        check("midrst_byte_count", 32'(byte_cnt), 32'd13);

        // Enable dropped mid-frame: the rest of an all-ones frame must not produce a byte
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (CPB / 2) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        repeat (8 * CPB) @(negedge clock);
        check("enable_abort", 32'(byte_cnt + ferr_cnt), 32'd14);

`ifdef UART_RX_PARITY_EN
        // 0x01 needs parity bit 1; send 0 instead
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i == 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (20) @(negedge clock);
        check("parity_err_count", 32'(perr_cnt), 32'd1);
        check("parity_no_byte", 32'(byte_cnt), 32'd13);
`else
        check("noparity_tied", 32'(perr_cnt), 32'd0);
`endif

        check("byte_queue_empty", 32'(exp_bytes.size()), 32'd0);
        check("word_queue_empty", 32'(exp_words.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
